// File: rtl/decoder_scan_nto2n_if.sv
// Bus bundle for the scanning N-to-2^N decoder: select/mode/trigger inputs in,
// one-hot strobe plus sweep status out.
interface decoder_scan_nto2n_if #(
    parameter int SEL_W = 4
);
    logic [SEL_W-1:0]      sel_in;
    logic                  en_in;
    logic [1:0]            mode_in;
    logic                  start_in;
    logic [(1<<SEL_W)-1:0] out;
    logic [SEL_W-1:0]      idx_out;
    logic                  busy_out;
    logic                  done_out;

    modport master (
        output sel_in, en_in, mode_in, start_in,
        input  out, idx_out, busy_out, done_out
    );

    modport slave (
        input  sel_in, en_in, mode_in, start_in,
        output out, idx_out, busy_out, done_out
    );
endinterface

// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with direct, continuous-scan and
// single-sweep modes; every output comes straight from a flop.
module decoder_scan_nto2n #(
    parameter int SEL_W      = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int DWELL      = 1
) (
    input logic                 clk,
    input logic                 rst,
    decoder_scan_nto2n_if.slave bus
);
    localparam int NOUT = 1 << SEL_W;
    localparam int DW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [NOUT-1:0]  out_q, out_d;
    logic             show_d;
    logic             enabled;
    logic             dwell_end;

    assign enabled   = !bus.en_in;
    assign dwell_end = (dwell_q == DWELL_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        show_d  = 1'b0;
        if (bus.mode_in != mode_q) begin
            // mode change aborts whatever was running, silently
            state_d = IDLE;
            idx_d   = '0;
            dwell_d = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    case (mode_q)
                        MODE_DIRECT: begin
                            if (enabled) begin
                                idx_d  = bus.sel_in;
                                show_d = 1'b1;
                            end
                        end
                        MODE_SCAN: begin
                            state_d = SCAN;
                            idx_d   = '0;
                            dwell_d = '0;
                            show_d  = enabled;
                        end
                        MODE_SWEEP: begin
                            if (bus.start_in) begin
                                state_d = SWEEP;
                                idx_d   = bus.sel_in;
                                dwell_d = '0;
                                busy_d  = 1'b1;
                                show_d  = enabled;
                            end
                        end
                        default: idx_d = '0;
                    endcase
                end
                SCAN: begin
                    if (enabled) begin
                        show_d = 1'b1;
                        if (dwell_end) begin
                            dwell_d = '0;
                            idx_d   = idx_q + SEL_W'(1);
                        end else begin
                            dwell_d = dwell_q + DW'(1);
                        end
                    end
                end
                SWEEP: begin
                    // disabled cycles freeze idx/dwell, so done can only fire when enabled
                    if (enabled) begin
                        if (!dwell_end) begin
                            dwell_d = dwell_q + DW'(1);
                            show_d  = 1'b1;
                        end else if (idx_q == '1) begin
                            dwell_d = '0;
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            dwell_d = '0;
                            idx_d   = idx_q + SEL_W'(1);
                            show_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // one comparator per output bit keeps the result one-hot or all-idle by construction
    for (genvar i = 0; i < NOUT; i++) begin : g_dec
        assign out_d[i] = (show_d && (idx_d == SEL_W'(i))) ^ POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_DIRECT;
            idx_q   <= '0;
            dwell_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= {NOUT{POL}};
        end else begin
            state_q <= state_d;
            mode_q  <= bus.mode_in;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign bus.out      = out_q;
    assign bus.idx_out  = idx_q;
    assign bus.busy_out = busy_q;
    assign bus.done_out = done_q;
endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Scoreboard bench: three decoder variants share stimulus; expected outputs are
// queued as each cycle is driven and compared after the following clock edge.
module tb_decoder_scan_nto2n;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decoder_scan_nto2n_if #(.SEL_W(4)) ia ();
    decoder_scan_nto2n_if #(.SEL_W(4)) ib ();
    decoder_scan_nto2n_if #(.SEL_W(3)) ic ();

    // a: dwell 2, b: dwell 1, c: 3-bit active-high
    decoder_scan_nto2n #(.SEL_W(4), .ACTIVE_LOW(1), .DWELL(2)) u_a (.clk(clk), .rst(rst), .bus(ia));
    decoder_scan_nto2n #(.SEL_W(4), .ACTIVE_LOW(1), .DWELL(1)) u_b (.clk(clk), .rst(rst), .bus(ib));
    decoder_scan_nto2n #(.SEL_W(3), .ACTIVE_LOW(0), .DWELL(1)) u_c (.clk(clk), .rst(rst), .bus(ic));

    typedef struct {
        string       tag;
        int          dut;
        logic [15:0] o;
        logic [3:0]  idx;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] act(input int dut, input int i);
        logic [15:0] one;
        one = 16'(1) << i;
        return (dut == 2) ? one : ~one;
    endfunction

    function automatic logic [15:0] inact(input int dut);
        return (dut == 2) ? 16'h0000 : 16'hFFFF;
    endfunction

    task automatic drive(input logic [3:0] sel, input logic en, input logic [1:0] mode, input logic start);
        ia.sel_in = sel;       ia.en_in = en; ia.mode_in = mode; ia.start_in = start;
        ib.sel_in = sel;       ib.en_in = en; ib.mode_in = mode; ib.start_in = start;
        ic.sel_in = sel[2:0];  ic.en_in = en; ic.mode_in = mode; ic.start_in = start;
    endtask

    task automatic push(input string tag, input int dut, input logic [15:0] o,
                        input int i, input logic b, input logic d);
        exp_t e;
        e.tag = tag; e.dut = dut; e.o = o; e.idx = 4'(i); e.busy = b; e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t        e;
        logic [15:0] go;
        logic [3:0]  gi;
        logic        gb, gd;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.dut)
                0:       begin go = ia.out; gi = ia.idx_out; gb = ia.busy_out; gd = ia.done_out; end
                1:       begin go = ib.out; gi = ib.idx_out; gb = ib.busy_out; gd = ib.done_out; end
                default: begin go = {8'h00, ic.out}; gi = {1'b0, ic.idx_out}; gb = ic.busy_out; gd = ic.done_out; end
            endcase
            chk({e.tag, ".out"},  32'(go), 32'(e.o));
            chk({e.tag, ".idx"},  32'(gi), 32'(e.idx));
            chk({e.tag, ".busy"}, 32'(gb), 32'(e.busy));
            chk({e.tag, ".done"}, 32'(gd), 32'(e.done));
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(4'd0, 1'b1, 2'b00, 1'b0);
        for (int d = 0; d < 3; d++) push($sformatf("rst%0d", d), d, inact(d), 0, 0, 0);
        tick();
        rst = 1'b0;

        // direct decode, enable gating, active-high variant
        drive(4'd5, 1'b0, 2'b00, 1'b0);
        push("dir5_a", 0, 16'hFFDF, 5, 0, 0);
        push("dir5_c", 2, 16'h0020, 5, 0, 0);
        tick();
        drive(4'd5, 1'b1, 2'b00, 1'b0);
        push("dis_a", 0, 16'hFFFF, 5, 0, 0);
        push("dis_c", 2, 16'h0000, 5, 0, 0);
        tick();
        drive(4'd6, 1'b0, 2'b00, 1'b0);
        push("dir6_a", 0, 16'hFFBF, 6, 0, 0);
        push("dir6_c", 2, 16'h0040, 6, 0, 0);
        tick();

        // continuous scan: a holds each index 2 cycles, b advances every cycle
        drive(4'd0, 1'b0, 2'b01, 1'b0);
        push("scan_enter", 0, 16'hFFFF, 0, 0, 0);
        tick();
        for (int k = 0; k < 34; k++) begin
            push($sformatf("scan_a%0d", k), 0, act(0, (k / 2) % 16), (k / 2) % 16, 0, 0);
            push($sformatf("scan_b%0d", k), 1, act(1, k % 16), k % 16, 0, 0);
            tick();
        end

        // sweep from 13 with a second start while busy
        drive(4'd13, 1'b0, 2'b10, 1'b0);
        push("swp_enter", 1, 16'hFFFF, 0, 0, 0);
        tick();
        drive(4'd13, 1'b0, 2'b10, 1'b1);
        push("swp13", 1, act(1, 13), 13, 1, 0);
        tick();
        drive(4'd2, 1'b0, 2'b10, 1'b1);
        push("swp14", 1, act(1, 14), 14, 1, 0);
        tick();
        drive(4'd2, 1'b0, 2'b10, 1'b0);
        push("swp15", 1, act(1, 15), 15, 1, 0);
        tick();
        push("swp_done", 1, 16'hFFFF, 15, 0, 1);
        tick();
        push("swp_after", 1, 16'hFFFF, 15, 0, 0);
        tick();

        // sweep starting at the last index: one dwell then done
        drive(4'd15, 1'b0, 2'b10, 1'b1);
        push("last_start", 1, 16'h7FFF, 15, 1, 0);
        tick();
        drive(4'd15, 1'b0, 2'b10, 1'b0);
        push("last_done", 1, 16'hFFFF, 15, 0, 1);
        tick();

        // sweep from 0 with a 3-cycle disable at index 7
        drive(4'd0, 1'b0, 2'b10, 1'b1);
        push("frz0", 1, act(1, 0), 0, 1, 0);
        tick();
        drive(4'd0, 1'b0, 2'b10, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            push($sformatf("frz%0d", k), 1, act(1, k), k, 1, 0);
            tick();
        end
        drive(4'd0, 1'b1, 2'b10, 1'b0);
        for (int k = 0; k < 3; k++) begin
            push($sformatf("frz_hold%0d", k), 1, 16'hFFFF, 7, 1, 0);
            tick();
        end
        drive(4'd0, 1'b0, 2'b10, 1'b0);
        for (int k = 8; k <= 15; k++) begin
            push($sformatf("frz%0d", k), 1, act(1, k), k, 1, 0);
            tick();
        end
        push("frz_done", 1, 16'hFFFF, 15, 0, 1);
        tick();
        push("frz_after", 1, 16'hFFFF, 15, 0, 0);
        tick();

        // mode change mid-sweep aborts without done
        drive(4'd0, 1'b0, 2'b10, 1'b1);
        push("mab0", 1, act(1, 0), 0, 1, 0);
        tick();
        drive(4'd0, 1'b0, 2'b10, 1'b0);
        push("mab1", 1, act(1, 1), 1, 1, 0);
        tick();
        drive(4'd3, 1'b0, 2'b00, 1'b0);
        push("mab_abort", 1, 16'hFFFF, 0, 0, 0);
        tick();
        push("mab_direct", 1, act(1, 3), 3, 0, 0);
        tick();

        // reset mid-sweep
        drive(4'd0, 1'b0, 2'b10, 1'b0);
        push("rab_enter", 1, 16'hFFFF, 0, 0, 0);
        tick();
        drive(4'd0, 1'b0, 2'b10, 1'b1);
        push("rab0", 1, act(1, 0), 0, 1, 0);
        tick();
        drive(4'd0, 1'b0, 2'b10, 1'b0);
        push("rab1", 1, act(1, 1), 1, 1, 0);
        tick();
        rst = 1'b1;
        push("rab_rst_b", 1, 16'hFFFF, 0, 0, 0);
        push("rab_rst_a", 0, 16'hFFFF, 0, 0, 0);
        tick();
        rst = 1'b0;
        push("rab_post", 1, 16'hFFFF, 0, 0, 0);
        tick();

        // active-high direct then OFF
        drive(4'd6, 1'b0, 2'b00, 1'b0);
        push("c_enter", 2, 16'h0000, 0, 0, 0);
        tick();
        push("c_dir6", 2, 16'h0040, 6, 0, 0);
        tick();
        drive(4'd6, 1'b0, 2'b11, 1'b1);
        push("c_off0", 2, 16'h0000, 0, 0, 0);
        push("a_off0", 0, 16'hFFFF, 0, 0, 0);
        tick();
        push("c_off1", 2, 16'h0000, 0, 0, 0);
        push("b_off1", 1, 16'hFFFF, 0, 0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/decoder_scan_nto2n.md
Name: decoder_scan_nto2n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with selectable output polarity and an active-low enable.
- Adds two sequenced modes on top of direct decode: continuous auto-scan and single triggered sweep, with a busy/done handshake.
- Drives row/column strobes and chip-select fans in the display and peripheral-select paths, replacing ad-hoc counter-plus-decoder pairs.

Parameters:
SEL_W, 4, select width N; output width is 2^SEL_W; legal range 1..6.
ACTIVE_LOW, 1, 1: asserted output bit is 0 and idle bits are 1; 0: the inverse.
DWELL, 1, enabled clock cycles each index is held in SCAN/SWEEP; legal range 1..65535.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
sel_in  input  SEL_W  direct-mode index; also the SWEEP start index, sampled on start_in.
en_in  input  1  active-low enable; 1 freezes sequencing and forces outputs inactive.
mode_in  input  2  00 DIRECT, 01 SCAN, 10 SWEEP, 11 OFF.
start_in  input  1  SWEEP trigger, single-cycle pulse.
out  output  2^SEL_W  registered one-hot (polarity per ACTIVE_LOW).
idx_out  output  SEL_W  index currently driven on out.
busy_out  output  1  high while a SWEEP is in progress.
done_out  output  1  one-cycle pulse when a SWEEP completes.

Behaviour:
- Reset (rst=1 at a clock edge) sets state IDLE, out to all-inactive (all 1s if ACTIVE_LOW, else 0s), idx_out=0, busy_out=0, done_out=0, dwell counter=0. Reset overrides every other input.
- "Inactive" means every bit of out is at its idle level.
- "Enabled" means en_in=0.
- State machine has three states: IDLE, SCAN, SWEEP.
- The registered mode_in is compared every cycle. Any change of mode_in aborts the current activity in the same edge: state←IDLE, idx←0, dwell←0, busy←0, out←inactive, and no done pulse.
- DIRECT (IDLE, mode 00):
  - Enabled: out←decode(sel_in) and idx_out←sel_in; latency 1 clock.
  - Disabled: out←inactive; idx_out holds.
- SCAN (mode 01):
  - IDLE moves to SCAN on the cycle after the mode is registered; idx starts at 0.
  - While enabled: out=decode(idx). The dwell counter counts 0..DWELL-1; at DWELL-1 it resets and idx increments, wrapping 2^SEL_W-1 → 0.
  - With DWELL=1, idx advances every enabled cycle.
- SWEEP (mode 10):
  - In IDLE, start_in=1 captures idx←sel_in, sets busy←1, state←SWEEP; the first index appears on out on the following edge.
  - idx advances like SCAN. After the index 2^SEL_W-1 dwell completes:
    - state←IDLE, busy←0, out←inactive;
    - done_out=1 for exactly one cycle, coincident with busy falling.
  - start_in is ignored while busy_out=1 and in any mode other than 10.
  - A start index of 2^SEL_W-1 produces one dwell period, then done.
- OFF (mode 11): out inactive, idx_out=0, busy_out=0.
- Enable handling in SCAN/SWEEP:
  - en_in=1 forces out inactive from the next edge and freezes idx and dwell; busy_out is unaffected.
  - Deasserting en_in resumes at the frozen idx with the remaining dwell.
  - done_out cannot fire while disabled.
- Outputs are exactly one-hot or all-inactive; never multi-hot.
- All outputs are registered; there is no combinational input→output path.
- Reset mid-sweep aborts with no done pulse.

Test Plan:
- SEL_W=4, ACTIVE_LOW=1, mode 00, en_in=0, sel_in=5 → next cycle out=16'hFFDF, idx_out=5; en_in=1 → out=16'hFFFF, idx_out=5.
- Mode 01, DWELL=2, enabled for 34 cycles → idx sequence 0,0,1,1,…,15,15,0,0 with wrap at 15→0; out=~(1<<idx) every cycle.
- Mode 10, DWELL=1, sel_in=13, start_in pulse → busy=1; out shows idx 13,14,15 on three consecutive cycles; then out=16'hFFFF, busy=0 and done_out=1 for one cycle; a second start_in during busy has no effect.
- Mode 10 sweep from 0: en_in=1 for 3 cycles at idx=7 → out=16'hFFFF and idx_out holds 7; re-enable → sweep resumes at 7 with total enabled length unchanged and done after idx 15.
- Mid-sweep, mode_in→00, or rst=1 → next edge busy=0, done_out stays 0, out=inactive (mode-change case) or reset values (reset case).
- ACTIVE_LOW=0, SEL_W=3, mode 00, sel_in=6 → out=8'h40; mode 11 → out=8'h00, idx_out=0.
